// File: rtl/param_updown_counter.sv
// Modulo-MODULUS up/down counter with synchronous load, optional saturation,
// a one-cycle terminal-count pulse and sticky overflow/underflow flags.
module param_updown_counter #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             upordown,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 64'd1);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("param_updown_counter: WIDTH must be 2..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("param_updown_counter: MODULUS must be 2..2**WIDTH");
    end
  endgenerate

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;

  // Out-of-range load values clamp to the top state so count never leaves 0..MODULUS-1.
  always_comb begin
    at_max       = (count == MAX_COUNT);
    at_zero      = (count == '0);
    load_clamped = (64'(load_val) < MODULUS) ? load_val : MAX_COUNT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in this block wins,
      // which is how a flag set beats clr_flags on the same edge.
      tc  <= 1'b0;
      ovf <= ovf & ~clr_flags;
      unf <= unf & ~clr_flags;
      if (load) begin
        count <= load_clamped;
      end else if (en) begin
        if (upordown) begin
          if (at_max) begin
            count <= SATURATE ? MAX_COUNT : '0;
            tc    <= 1'b1;
            ovf   <= 1'b1;
          end else begin
            count <= count + WIDTH'(1);
          end
        end else begin
          if (at_zero) begin
            count <= SATURATE ? '0 : MAX_COUNT;
            tc    <= 1'b1;
            unf   <= 1'b1;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: drivers queue hand-computed expectations, a monitor pops
// one per clock and compares against the addressed counter instance.
module tb_param_updown_counter;

  typedef struct {
    bit          dut;
    logic [3:0]  count;
    logic        tc;
    logic        ovf;
    logic        unf;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       a_reset, a_en, a_ud, a_load, a_clr;
  logic [3:0] a_lv;
  logic [3:0] a_count;
  logic       a_tc, a_ovf, a_unf;
  logic       b_reset, b_en, b_ud, b_load, b_clr;
  logic [3:0] b_lv;
  logic [3:0] b_count;
  logic       b_tc, b_ovf, b_unf;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  always #5 clk = ~clk;

  // Instance A: defaults (WIDTH 4, MODULUS 16, wrap).
  param_updown_counter dut_a (
    .clk(clk), .reset(a_reset), .en(a_en), .upordown(a_ud), .load(a_load),
    .load_val(a_lv), .clr_flags(a_clr), .count(a_count), .tc(a_tc),
    .ovf(a_ovf), .unf(a_unf)
  );

  // Instance B: MODULUS 10, saturating.
  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset(b_reset), .en(b_en), .upordown(b_ud), .load(b_load),
    .load_val(b_lv), .clr_flags(b_clr), .count(b_count), .tc(b_tc),
    .ovf(b_ovf), .unf(b_unf)
  );

  // One stimulus cycle: drive on the falling edge and queue what the next rising edge must produce.
  task automatic step(input bit d, input logic rst, input logic ld, input logic [3:0] lv,
                      input logic e, input logic ud, input logic cl,
                      input logic [3:0] ec, input logic et, input logic eo, input logic eu,
                      input string nm);
    exp_t x;
    @(negedge clk);
    {a_reset, a_load, a_lv, a_en, a_ud, a_clr} = {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    {b_reset, b_load, b_lv, b_en, b_ud, b_clr} = {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    if (d == 1'b0) {a_reset, a_load, a_lv, a_en, a_ud, a_clr} = {rst, ld, lv, e, ud, cl};
    else           {b_reset, b_load, b_lv, b_en, b_ud, b_clr} = {rst, ld, lv, e, ud, cl};
    x.dut = d; x.count = ec; x.tc = et; x.ovf = eo; x.unf = eu; x.name = nm;
    q.push_back(x);
  endtask

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got count=%0d tc=%b ovf=%b unf=%b, expected count=%0d tc=%b ovf=%b unf=%b",
               nm, act[6:3], act[2], act[1], act[0], req[6:3], req[2], req[1], req[0]);
    end
  endtask

  // Monitor: the counter presents a new output every rising edge.
  initial begin
    exp_t x;
    logic [6:0] act;
    while (!done) begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x   = q.pop_front();
        act = x.dut ? {b_count, b_tc, b_ovf, b_unf} : {a_count, a_tc, a_ovf, a_unf};
        check(x.name, act, {x.count, x.tc, x.ovf, x.unf});
      end
    end
  end

  initial begin
    {a_reset, a_load, a_lv, a_en, a_ud, a_clr} = '0;
    {b_reset, b_load, b_lv, b_en, b_ud, b_clr} = '0;

    // Default instance: reset then count up through the wrap.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 1, 1, 4'd0, 0, 0, 0, "a_reset");
    for (int i = 1; i <= 18; i++) begin
      logic [3:0] c;
      c = 4'(i % 16);
      step(0, 0, 0, 0, 1, 1, 0, c, (i == 16), (i >= 16), 0, "a_up");
    end
    step(0, 0, 0, 0, 0, 0, 1, 4'd2, 0, 0, 0, "a_clr_flags");

    // Count down from 0 wraps to 15 with a single tc pulse and sticky unf.
    step(0, 0, 1, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, "a_load0");
    step(0, 0, 0, 0, 1, 0, 0, 4'd15, 1, 0, 1, "a_down_wrap");
    step(0, 0, 0, 0, 1, 0, 0, 4'd14, 0, 0, 1, "a_down1");
    step(0, 0, 0, 0, 1, 0, 0, 4'd13, 0, 0, 1, "a_down2");

    // Reset mid-count aborts the step and clears flags; counting resumes from 0.
    step(0, 0, 1, 4'd7, 0, 0, 0, 4'd7, 0, 0, 1, "a_load7");
    step(0, 0, 0, 0, 1, 1, 0, 4'd8, 0, 0, 1, "a_up_from7");
    step(0, 1, 0, 0, 1, 1, 0, 4'd0, 0, 0, 0, "a_reset_midcount");
    step(0, 0, 0, 0, 1, 1, 0, 4'd1, 0, 0, 0, "a_resume");

    // Overflow and clr_flags on the same edge: set wins.
    step(0, 0, 1, 4'd15, 0, 0, 0, 4'd15, 0, 0, 0, "a_load15");
    step(0, 0, 0, 0, 1, 1, 1, 4'd0, 1, 1, 0, "a_ovf_beats_clr");

    // Hold with en low while direction toggles.
    step(0, 0, 1, 4'd5, 0, 0, 0, 4'd5, 0, 1, 0, "a_load5");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1'(i), 0, 4'd5, 0, 1, 0, "a_hold");

    // Direction changes take effect on the very next enabled edge.
    step(0, 0, 0, 0, 1, 1, 0, 4'd6, 0, 1, 0, "a_dir_up");
    step(0, 0, 0, 0, 1, 0, 0, 4'd5, 0, 1, 0, "a_dir_down");
    step(0, 0, 0, 0, 1, 1, 0, 4'd6, 0, 1, 0, "a_dir_up2");
    step(0, 0, 0, 0, 0, 0, 1, 4'd6, 0, 0, 0, "a_clr_only");

    // Saturating MODULUS=10 instance.
    step(1, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, "b_reset");
    step(1, 0, 1, 4'd8, 0, 0, 0, 4'd8, 0, 0, 0, "b_load8");
    step(1, 0, 0, 0, 1, 1, 0, 4'd9, 0, 0, 0, "b_sat_up0");
    step(1, 0, 0, 0, 1, 1, 0, 4'd9, 1, 1, 0, "b_sat_up1");
    step(1, 0, 0, 0, 1, 1, 0, 4'd9, 1, 1, 0, "b_sat_up2");
    step(1, 0, 0, 0, 1, 1, 0, 4'd9, 1, 1, 0, "b_sat_up3");
    step(1, 0, 0, 0, 0, 1, 0, 4'd9, 0, 1, 0, "b_idle");
    step(1, 0, 1, 4'd12, 0, 0, 0, 4'd9, 0, 1, 0, "b_load_clamp");
    step(1, 0, 1, 4'd3, 1, 1, 0, 4'd3, 0, 1, 0, "b_load_beats_en");
    step(1, 0, 0, 0, 1, 0, 0, 4'd2, 0, 1, 0, "b_down0");
    step(1, 0, 0, 0, 1, 0, 0, 4'd1, 0, 1, 0, "b_down1");
    step(1, 0, 0, 0, 1, 0, 0, 4'd0, 0, 1, 0, "b_down2");
    step(1, 0, 0, 0, 1, 0, 0, 4'd0, 1, 1, 1, "b_sat_down0");
    step(1, 0, 0, 0, 1, 0, 1, 4'd0, 1, 0, 1, "b_unf_beats_clr");
    step(1, 0, 0, 0, 0, 0, 1, 4'd0, 0, 0, 0, "b_clr_only");
    step(1, 0, 1, 4'd15, 0, 0, 0, 4'd9, 0, 0, 0, "b_load_max_clamp");

    // Drain the scoreboard within a bounded number of cycles.
    @(negedge clk);
    {b_reset, b_load, b_en, b_clr} = '0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, count register width in bits (legal 2..32).
REQ-002 Parameter MODULUS, default 16, number of count states, 0..MODULUS-1 (legal 2..2^WIDTH).
REQ-003 Parameter SATURATE, default 0; 0 = wrap at limits, 1 = hold at limits.
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-006 Port en  input  1  count enable; counter holds when 0.
REQ-007 Port upordown  input  1  direction; 1 = count up, 0 = count down.
REQ-008 Port load  input  1  synchronous load strobe.
REQ-009 Port load_val  input  WIDTH  value loaded when load=1.
REQ-010 Port clr_flags  input  1  clears sticky ovf/unf flags.
REQ-011 Port count  output  WIDTH  current count, registered.
REQ-012 Port tc  output  1  terminal-count pulse, registered, one cycle.
REQ-013 Port ovf  output  1  sticky flag, set on up-step from MODULUS-1.
REQ-014 Port unf  output  1  sticky flag, set on down-step from 0.

Function
REQ-015 Priority per edge: reset > load > en; lower-priority inputs ignored that cycle.
REQ-016 load=1: count <= load_val if load_val < MODULUS, else count <= MODULUS-1; tc <= 0; flags unaffected except by clr_flags.
REQ-017 en=1, upordown=1, count < MODULUS-1: count <= count+1, tc <= 0.
REQ-018 en=1, upordown=1, count = MODULUS-1: count <= 0 (SATURATE=0) or holds MODULUS-1 (SATURATE=1); tc <= 1; ovf <= 1.
REQ-019 en=1, upordown=0, count > 0: count <= count-1, tc <= 0.
REQ-020 en=1, upordown=0, count = 0: count <= MODULUS-1 (SATURATE=0) or holds 0 (SATURATE=1); tc <= 1; unf <= 1.
REQ-021 en=0 and load=0: count holds, tc <= 0.
REQ-022 tc high exactly one cycle per limit event; in SATURATE=1 with en held at a limit, tc re-asserts every enabled cycle (continuous high).
REQ-023 Latency: count and tc reflect inputs sampled at edge N after edge N; no combinational input-to-output path.
REQ-024 clr_flags=1: ovf <= 0 and unf <= 0, unless a set event occurs the same edge, in which case set wins.
REQ-025 Direction change takes effect on the next enabled edge; no dead cycle.
REQ-026 Arithmetic is modulo MODULUS, never modulo 2^WIDTH; count never exceeds MODULUS-1.

Reset
REQ-027 reset=1 at an edge: count <= 0, tc <= 0, ovf <= 0, unf <= 0, regardless of all other inputs.
REQ-028 reset asserted mid-count aborts the operation that edge; counting resumes from 0 on the first enabled edge after reset deasserts.
REQ-029 Before the first reset edge, outputs are undefined; bench shall not check them.

Verification
REQ-030 Defaults, reset 3 cycles then en=1, upordown=1 for 18 cycles -> count 1..15,0,1,2; tc=1 and ovf=1 on the cycle count becomes 0.
REQ-031 Defaults, count=0, upordown=0, en=1 for 3 cycles -> count 15,14,13; tc=1 only first cycle; unf=1 sticky thereafter.
REQ-032 MODULUS=10, SATURATE=1, up from 8 for 4 cycles -> count 9,9,9,9; tc=0,1,1,1; ovf=1.
REQ-033 MODULUS=10, load=1, load_val=12 -> count=9; load=1 with en=1 same edge -> load wins.
REQ-034 Defaults, counting at 7, reset=1 one cycle -> count=0, flags 0; clr_flags and overflow same edge -> ovf remains 1.
REQ-035 en=0 for 5 cycles at count=5 with upordown toggling -> count stays 5, tc=0.
